// File: rtl/x_buffer_ctrl.sv
// Sequencer for the 4-slot X row buffer: primes three rows, then alternates
// ALU shift passes with single-row reloads until the frame is exhausted.
module x_buffer_ctrl #(
   parameter int WORDS_PER_ROW  = 27,
   parameter int SHIFTS_PER_ROW = 8,
   parameter int NUM_ROWS       = 28,
   parameter int CNT_W          = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       load_en,
   output logic       valid_input,
   output logic [1:0] row_counter,
   output logic       ALU_en,
   input  logic       alu_ready,
   output logic       busy,
   output logic       done,
   output logic [7:0] row_idx
);

   typedef enum logic [2:0] {IDLE, PRIME, COMPUTE, LOAD, FIN} state_t;

   localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(WORDS_PER_ROW - 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SHIFTS_PER_ROW - 1);
   localparam logic [7:0]       ROW_END    = 8'(NUM_ROWS);

   state_t           state, state_n;
   logic [CNT_W-1:0] beat_cnt, beat_n;
   logic [CNT_W-1:0] shift_cnt, shift_n;
   logic [7:0]       row_idx_n;
   logic [1:0]       row_counter_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         beat_cnt    <= '0;
         shift_cnt   <= '0;
         row_idx     <= '0;
         row_counter <= '0;
      end else begin
         state       <= state_n;
         beat_cnt    <= beat_n;
         shift_cnt   <= shift_n;
         row_idx     <= row_idx_n;
         row_counter <= row_counter_n;
      end
   end

   always_comb begin
      state_n       = state;
      beat_n        = beat_cnt;
      shift_n       = shift_cnt;
      row_idx_n     = row_idx;
      row_counter_n = row_counter;

      case (state)
         IDLE: begin
            if (start) begin
               state_n       = PRIME;
               row_counter_n = '0;
               row_idx_n     = '0;
               beat_n        = '0;
            end
         end
         PRIME, LOAD: begin
            if (in_valid) begin
               if (beat_cnt == LAST_BEAT) begin
                  beat_n    = '0;
                  row_idx_n = row_idx + 8'd1;
                  // Priming fills slots 0..2 before the first shift pass
                  if (state == LOAD || row_counter == 2'd2) begin
                     state_n = COMPUTE;
                  end else begin
                     row_counter_n = row_counter + 2'd1;
                  end
               end else begin
                  beat_n = beat_cnt + 1'b1;
               end
            end
         end
         COMPUTE: begin
            if (alu_ready) begin
               if (shift_cnt == LAST_SHIFT) begin
                  shift_n = '0;
                  if (row_idx == ROW_END) begin
                     state_n = FIN;
                  end else begin
                     state_n       = LOAD;
                     row_counter_n = row_counter + 2'd1;
                  end
               end else begin
                  shift_n = shift_cnt + 1'b1;
               end
            end
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Abort beats any transition; in IDLE it only suppresses a start
      if (abort) begin
         state_n = IDLE;
         if (state == IDLE) begin
            beat_n        = beat_cnt;
            shift_n       = shift_cnt;
            row_idx_n     = row_idx;
            row_counter_n = row_counter;
         end else begin
            beat_n        = '0;
            shift_n       = '0;
            row_idx_n     = '0;
            row_counter_n = '0;
         end
      end
   end

   assign in_ready    = (state == PRIME) || (state == LOAD);
   assign load_en     = in_ready;
   assign valid_input = in_valid && in_ready;
   assign ALU_en      = (state == COMPUTE) && alu_ready;
   assign busy        = (state != IDLE);
   assign done        = (state == FIN);

endmodule

// File: tb/tb_x_buffer_ctrl.sv
// Self-checking bench for x_buffer_ctrl: three parameterisations, a slot
// scoreboard filled at frame start and drained by a negedge monitor.
module tb_x_buffer_ctrl;

   // Instance 0: defaults, 1: wrap-around (6 rows, 2 words), 2: random gaps
   localparam logic [2:0][7:0] NR = {8'd4, 8'd6, 8'd28};
   localparam logic [2:0][7:0] WR = {8'd3, 8'd2, 8'd27};
   localparam logic [2:0][7:0] SR = {8'd2, 8'd2, 8'd8};

   logic       clk;
   logic       rst;
   logic [2:0] start, abort, in_valid, alu_ready;
   logic       in_ready[3], load_en[3], valid_input[3], alu_en[3], busy[3], done[3];
   logic [1:0] row_counter[3];
   logic [7:0] row_idx[3];

   int checks = 0, passes = 0;
   int loadQ[$], aluQ[$];
   int curBeat, curShift, beatCnt, shiftCnt, doneCnt, doneCyc, frameCyc;
   int doneRowIdx, doneRc;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      x_buffer_ctrl #(
         .WORDS_PER_ROW (int'(WR[g])),
         .SHIFTS_PER_ROW(int'(SR[g])),
         .NUM_ROWS      (int'(NR[g])),
         .CNT_W         (5)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start[g]),
         .abort      (abort[g]),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .load_en    (load_en[g]),
         .valid_input(valid_input[g]),
         .row_counter(row_counter[g]),
         .ALU_en     (alu_en[g]),
         .alu_ready  (alu_ready[g]),
         .busy       (busy[g]),
         .done       (done[g]),
         .row_idx    (row_idx[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   task automatic clearBoard();
      loadQ.delete();
      aluQ.delete();
      curBeat  = 0;
      curShift = 0;
   endtask

   // Row r always lands in slot r mod 4; shift pass k sees slot (k+2) mod 4
   task automatic applyStimulus(input int g);
      clearBoard();
      beatCnt = 0; shiftCnt = 0; doneCnt = 0; doneCyc = 0;
      doneRowIdx = -1; doneRc = -1;
      for (int r = 0; r < int'(NR[g]); r++) loadQ.push_back(r % 4);
      for (int k = 0; k < int'(NR[g]) - 2; k++) aluQ.push_back((k + 2) % 4);
      @(posedge clk); #1 start[g] = 1'b1;
      @(posedge clk); #1 start[g] = 1'b0;
      frameCyc = 0;
   endtask

   task automatic runFrame(input int g, input int pv, input int pr, input int budget);
      int n = 0;
      in_valid[g]  = ($urandom_range(99) < pv);
      alu_ready[g] = ($urandom_range(99) < pr);
      while (busy[g] && n < budget) begin
         @(posedge clk); #1;
         in_valid[g]  = ($urandom_range(99) < pv);
         alu_ready[g] = ($urandom_range(99) < pr);
         n++;
      end
      checkOutput("frame_timeout", int'(busy[g]), 0);
      in_valid[g]  = 1'b0;
      alu_ready[g] = 1'b0;
   endtask

   task automatic checkFrame(input int g);
      checkOutput("beats", beatCnt, int'(NR[g]) * int'(WR[g]));
      checkOutput("shifts", shiftCnt, int'(SR[g]) * (int'(NR[g]) - 2));
      checkOutput("done_count", doneCnt, 1);
      checkOutput("queue_left", loadQ.size() + aluQ.size(), 0);
   endtask

   // Monitor: drains the slot scoreboard and counts beats, shifts and done
   always @(negedge clk) begin
      frameCyc++;
      for (int g = 0; g < 3; g++) begin
         checkOutput("load_alu_excl", int'(load_en[g] & alu_en[g]), 0);
         checkOutput("alu_gate", int'(alu_en[g] & ~alu_ready[g]), 0);
         checkOutput("vi_gate", int'(valid_input[g] & ~in_valid[g]), 0);
         if (valid_input[g]) begin
            beatCnt++;
            if (loadQ.size() == 0) checkOutput("load_extra", int'(valid_input[g]), 0);
            else begin
               checkOutput("load_slot", int'(row_counter[g]), loadQ[0]);
               curBeat++;
               if (curBeat == int'(WR[g])) begin
                  void'(loadQ.pop_front());
                  curBeat = 0;
               end
            end
         end
         if (alu_en[g]) begin
            shiftCnt++;
            if (aluQ.size() == 0) checkOutput("alu_extra", int'(alu_en[g]), 0);
            else begin
               checkOutput("alu_slot", int'(row_counter[g]), aluQ[0]);
               curShift++;
               if (curShift == int'(SR[g])) begin
                  void'(aluQ.pop_front());
                  curShift = 0;
               end
            end
         end
         if (done[g]) begin
            doneCnt++;
            doneCyc    = frameCyc;
            doneRowIdx = int'(row_idx[g]);
            doneRc     = int'(row_counter[g]);
         end
      end
   end

   initial begin : stimulus
      int n;
      int expDone;
      rst = 1'b1; start = '0; abort = '0; in_valid = '0; alu_ready = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", int'(busy[0]), 0);
      checkOutput("rst_in_ready", int'(in_ready[0]), 0);
      checkOutput("rst_alu_en", int'(alu_en[0]), 0);
      checkOutput("rst_done", int'(done[0]), 0);
      checkOutput("rst_rc", int'(row_counter[0]), 0);
      checkOutput("rst_row_idx", int'(row_idx[0]), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full-rate frame with default parameters
      expDone = 3 * 27 + 8 + (28 - 3) * (27 + 8) + 1;
      applyStimulus(0);
      checkOutput("start_busy", int'(busy[0]), 1);
      runFrame(0, 100, 100, 3000);
      checkFrame(0);
      checkOutput("done_cycle", doneCyc, expDone);

      // start pulsed during COMPUTE must not disturb the frame
      applyStimulus(0);
      in_valid[0] = 1'b1; alu_ready[0] = 1'b1;
      n = 0;
      while (!alu_en[0] && n < 200) begin @(posedge clk); #1; n++; end
      checkOutput("reach_compute", int'(alu_en[0]), 1);
      start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      checkOutput("start_ignored", int'(load_en[0]), 0);
      runFrame(0, 100, 100, 3000);
      checkFrame(0);
      checkOutput("done_cycle_2", doneCyc, expDone);

      // Random gaps on both handshakes, small frame
      applyStimulus(2);
      runFrame(2, 50, 70, 2000);
      checkFrame(2);
      checkOutput("gap_final_rc", doneRc, 3);

      // Wrap-around of the slot selector
      applyStimulus(1);
      runFrame(1, 100, 100, 500);
      checkFrame(1);
      checkOutput("wrap_row_idx", doneRowIdx, 6);
      checkOutput("wrap_final_rc", doneRc, 1);

      // Abort on the 5th beat of the second LOAD
      applyStimulus(0);
      in_valid[0] = 1'b1; alu_ready[0] = 1'b1;
      n = 0;
      while (!(row_idx[0] == 8'd4 && load_en[0]) && n < 400) begin @(posedge clk); #1; n++; end
      checkOutput("reach_load2", int'(row_idx[0]), 4);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("abort_in_load", int'(load_en[0]), 1);
      abort[0] = 1'b1;
      @(posedge clk); #1 abort[0] = 1'b0;
      checkOutput("abort_busy", int'(busy[0]), 0);
      checkOutput("abort_rc", int'(row_counter[0]), 0);
      checkOutput("abort_row_idx", int'(row_idx[0]), 0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("abort_no_done", doneCnt, 0);
      checkOutput("abort_stays_idle", int'(busy[0]), 0);
      applyStimulus(0);
      checkOutput("restart_rc", int'(row_counter[0]), 0);
      checkOutput("restart_row_idx", int'(row_idx[0]), 0);
      checkOutput("restart_ready", int'(in_ready[0]), 1);
      abort[0] = 1'b1;
      @(posedge clk); #1 abort[0] = 1'b0;
      in_valid[0] = 1'b0;
      clearBoard();

      // start and abort together in IDLE
      start[0] = 1'b1; abort[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0; abort[0] = 1'b0;
      checkOutput("start_abort_busy", int'(busy[0]), 0);
      checkOutput("start_abort_ready", int'(in_ready[0]), 0);

      // Asynchronous reset in the middle of PRIME
      applyStimulus(0);
      in_valid[0] = 1'b1;
      repeat (60) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("arst_busy", int'(busy[0]), 0);
      checkOutput("arst_load_en", int'(load_en[0]), 0);
      checkOutput("arst_valid_input", int'(valid_input[0]), 0);
      checkOutput("arst_rc", int'(row_counter[0]), 0);
      checkOutput("arst_row_idx", int'(row_idx[0]), 0);
      #2 rst = 1'b0;
      clearBoard();
      repeat (5) @(posedge clk);
      #1;
      checkOutput("arst_stays_idle", int'(busy[0]), 0);
      checkOutput("arst_no_done", doneCnt, 0);
      in_valid[0] = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
